// File: rtl/fault_detector.sv
// Fault detector: flags illegal opcodes, inconsistent control bundles and a stuck ALU result,
// reports each event once per hold/blank recovery window and checkpoints the last clean-commit PC.
module fault_detector #(
    parameter int unsigned STUCK_LIMIT = 16,
    parameter int unsigned FAULT_HOLD  = 2,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instr,
    input  logic [7:0]      ctrl_bus,
    input  logic [XLEN-1:0] alu_result,
    input  logic            commit,
    input  logic [XLEN-1:0] pc_current,
    output logic            illegal_opcode,
    output logic            invalid_control,
    output logic            stuck_at_fault,
    output logic [XLEN-1:0] pc_saved,
    output logic [7:0]      fault_count
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned HOLD_W = 4;
    // The compare that moves the counter onto STUCK_LIMIT-1 is the one that declares the fault.
    localparam logic [CNT_W-1:0]  STUCK_HIT = CNT_W'(STUCK_LIMIT - 2);
    localparam logic [CNT_W-1:0]  STUCK_SAT = CNT_W'(STUCK_LIMIT);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FAULT_HOLD - 1);
    localparam logic [7:0]        COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_MONITOR = 2'd0,
        ST_HOLD    = 2'd1,
        ST_BLANK   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  stuck_cnt;
    logic [XLEN-1:0]   last_result;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [2:0]        flags_d;
    logic [XLEN-1:0]   pc_saved_d;
    logic [7:0]        fault_count_d;

    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic branch;
    logic jump;
    logic mem_to_reg;
    logic opcode_known;
    logic illegal_c;
    logic invalid_c;
    logic result_match;
    logic stuck_c;
    logic detect_c;
    logic unused_bits;

    assign reg_write  = ctrl_bus[6];
    assign mem_write  = ctrl_bus[5];
    assign mem_read   = ctrl_bus[4];
    assign branch     = ctrl_bus[3];
    assign jump       = ctrl_bus[2];
    assign mem_to_reg = ctrl_bus[0];

    // pc_write, alu_src and the upper instruction bits play no part in classification
    assign unused_bits = ^{ctrl_bus[7], ctrl_bus[1], instr[XLEN-1:7]};

    always_comb begin
        opcode_known = 1'b0;
        case (instr[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011:
                opcode_known = 1'b1;
            default:
                opcode_known = 1'b0;
        endcase
    end

    assign illegal_c = instr_valid & ((instr[1:0] != 2'b11) | ~opcode_known);

    assign invalid_c = instr_valid & ((mem_write & mem_read)
                                    | (mem_write & reg_write)
                                    | (branch & jump)
                                    | (mem_to_reg & ~mem_read)
                                    | (mem_read & ~reg_write));

    assign result_match = (alu_result == last_result);
    assign stuck_c      = instr_valid & result_match & (stuck_cnt == STUCK_HIT);

    // Only MONITOR may open a new event; HOLD and BLANK mask every detector.
    assign detect_c = (state_q == ST_MONITOR) & (illegal_c | invalid_c | stuck_c);

    // Stuck-at tracker runs in every FSM state so a long run is not lost during recovery
    always_ff @(posedge clk) begin
        if (reset) begin
            stuck_cnt   <= '0;
            last_result <= '0;
        end else if (instr_valid) begin
            last_result <= alu_result;
            if (stuck_c || !result_match) begin
                stuck_cnt <= '0;
            end else if (stuck_cnt != STUCK_SAT) begin
                stuck_cnt <= stuck_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_MONITOR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MONITOR: if (detect_c) state_d = ST_HOLD;
            ST_HOLD:    if (hold_cnt == '0) state_d = ST_BLANK;
            ST_BLANK:   state_d = ST_MONITOR;
            default:    state_d = ST_MONITOR;
        endcase
    end

    // Next values of the registered outputs and the hold timer
    always_comb begin
        flags_d       = {illegal_opcode, invalid_control, stuck_at_fault};
        hold_cnt_d    = hold_cnt;
        pc_saved_d    = pc_saved;
        fault_count_d = fault_count;
        case (state_q)
            ST_MONITOR: begin
                if (detect_c) begin
                    flags_d    = {illegal_c, invalid_c, stuck_c};
                    hold_cnt_d = HOLD_INIT;
                    if (fault_count != COUNT_MAX) begin
                        fault_count_d = fault_count + 8'd1;
                    end
                end else begin
                    flags_d = 3'b000;
                    if (commit) begin
                        pc_saved_d = pc_current;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    flags_d = 3'b000;
                end else begin
                    hold_cnt_d = hold_cnt - HOLD_W'(1);
                end
            end
            ST_BLANK: begin
                flags_d = 3'b000;
            end
            default: begin
                flags_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_opcode  <= 1'b0;
            invalid_control <= 1'b0;
            stuck_at_fault  <= 1'b0;
            hold_cnt        <= '0;
            pc_saved        <= '0;
            fault_count     <= '0;
        end else begin
            {illegal_opcode, invalid_control, stuck_at_fault} <= flags_d;
            hold_cnt    <= hold_cnt_d;
            pc_saved    <= pc_saved_d;
            fault_count <= fault_count_d;
        end
    end

endmodule
